gpr_regfile: RTL and testbench

//   Architectural integer register file (x0..x31) of the NPC core. Supplies two combinational read

---
 rtl/npc_pkg.sv | 11 +
 rtl/gpr_read_port.sv | 29 ++
 rtl/gpr_regfile.sv | 89 ++++++++
 tb/tb_gpr_regfile.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared NPC core constants: datapath width, register-file geometry and ABI register indices.
package npc_pkg;
    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd1;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;
    localparam logic [REG_ADDR_W-1:0] REG_A0   = 5'd10;
endpackage

// File: rtl/gpr_read_port.sv
// One combinational read port of the GPR file, with optional same-cycle bypass from the write port.
module gpr_read_port
    import npc_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [NREG*XLEN-1:0]  image,
    input  logic                  wen,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       data
);

    logic hit;

    assign hit = BYPASS && wen && (waddr == addr);

    // x0 is forced here so a write snoop to index 0 can never leak through the bypass.
    always_comb begin
        data = image[int'(addr)*XLEN +: XLEN];
        if (addr == REG_ZERO) begin
            data = '0;
        end else if (hit) begin
            data = wdata;
        end
    end

endmodule

// File: rtl/gpr_regfile.sv
// Architectural integer register file x0..x31 with two read ports, one write port and a
// difftest trace stage whose image already contains the committing instruction's write.
module gpr_regfile
    import npc_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [XLEN-1:0]       rs1_data,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs2_data,
    input  logic                  wen,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  commit_valid,
    input  logic [XLEN-1:0]       commit_pc,
    output logic                  trace_valid,
    output logic [XLEN-1:0]       trace_pc,
    output logic [NREG*XLEN-1:0]  trace_regs,
    output logic [63:0]           retire_cnt
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic            trace_valid_q, trace_valid_d;
    logic [XLEN-1:0] trace_pc_q, trace_pc_d;
    logic [63:0]     retire_cnt_q, retire_cnt_d;

    always_comb begin
        regs_d        = regs_q;
        trace_valid_d = commit_valid;
        trace_pc_d    = trace_pc_q;
        retire_cnt_d  = retire_cnt_q;
        if (wen && (waddr != REG_ZERO)) begin
            regs_d[waddr] = wdata;
        end
        if (commit_valid) begin
            trace_pc_d   = commit_pc;
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            retire_cnt_q  <= '0;
        end else begin
            regs_q        <= regs_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            retire_cnt_q  <= retire_cnt_d;
        end
    end

    // Image is the registered state only; writes show up here one edge after they are issued.
    assign trace_regs[XLEN-1:0] = '0;
    for (genvar g = 1; g < NREG; g++) begin : g_image
        assign trace_regs[g*XLEN +: XLEN] = regs_q[g];
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign retire_cnt  = retire_cnt_q;

    gpr_read_port #(.BYPASS(BYPASS)) u_rd1 (
        .addr  (rs1_addr),
        .image (trace_regs),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .data  (rs1_data)
    );

    gpr_read_port #(.BYPASS(BYPASS)) u_rd2 (
        .addr  (rs2_addr),
        .image (trace_regs),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .data  (rs2_data)
    );

endmodule

// File: tb/tb_gpr_regfile.sv
// Randomized bench for gpr_regfile: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array-based model of the register file and trace stage.
module tb_gpr_regfile;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    rs1_addr, rs2_addr, waddr;
    logic          wen, commit_valid;
    logic [63:0]   wdata, commit_pc;
    logic [63:0]   rs1_data, rs2_data, rs1_data_nb, rs2_data_nb;
    logic          trace_valid, trace_valid_nb;
    logic [63:0]   trace_pc, trace_pc_nb;
    logic [2047:0] trace_regs, trace_regs_nb;
    logic [63:0]   retire_cnt, retire_cnt_nb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_regs [32];
    logic        m_tv;
    logic [63:0] m_pc;
    logic [63:0] m_cnt;

    always #5 clock = ~clock;

    gpr_regfile #(.BYPASS(1'b1)) dut (
        .clock(clock), .reset(reset),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_regs(trace_regs), .retire_cnt(retire_cnt)
    );

    gpr_regfile #(.BYPASS(1'b0)) dut_nb (
        .clock(clock), .reset(reset),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data_nb),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data_nb),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .trace_valid(trace_valid_nb), .trace_pc(trace_pc_nb),
        .trace_regs(trace_regs_nb), .retire_cnt(retire_cnt_nb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [4:0] a, input bit bypass);
        if (a == 0) return 64'd0;
        if (bypass && wen && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_tv  = 1'b0;
        m_pc  = 64'd0;
        m_cnt = 64'd0;
    endtask

    task automatic check_trace();
        chk("trace_valid", {63'd0, trace_valid}, {63'd0, m_tv});
        chk("trace_pc", trace_pc, m_pc);
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("retire_cnt_nb", retire_cnt_nb, m_cnt);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("trace_regs[%0d]", i), trace_regs[i*64 +: 64], m_regs[i]);
        end
    endtask

    task automatic cycle(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic cv, input logic [63:0] pc);
        @(negedge clock);
        wen = w; waddr = wa; wdata = wd;
        rs1_addr = a1; rs2_addr = a2;
        commit_valid = cv; commit_pc = pc;
        #1;
        chk("rs1_data", rs1_data, m_read(a1, 1'b1));
        chk("rs2_data", rs2_data, m_read(a2, 1'b1));
        chk("rs1_data_nb", rs1_data_nb, m_read(a1, 1'b0));
        chk("rs2_data_nb", rs2_data_nb, m_read(a2, 1'b0));
        @(posedge clock);
        if (w && wa != 0) m_regs[wa] = wd;
        m_tv = cv;
        if (cv) begin
            m_pc  = pc;
            m_cnt = m_cnt + 64'd1;
        end
        #1;
        check_trace();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        wen = 1'b0; waddr = '0; wdata = '0;
        rs1_addr = '0; rs2_addr = '0;
        commit_valid = 1'b0; commit_pc = '0;
        m_reset();
        #12;
        check_trace();
        @(negedge clock);
        reset = 1'b0;

        // x0 writes are discarded
        cycle(1'b1, 5'd0, 64'hDEAD, 5'd0, 5'd0, 1'b0, 64'd0);
        cycle(1'b0, 5'd0, 64'd0,    5'd0, 5'd0, 1'b0, 64'd0);

        // same-cycle read of the register being written, both ports
        cycle(1'b1, 5'd7, 64'h55,   5'd7, 5'd7, 1'b0, 64'd0);
        cycle(1'b1, 5'd7, 64'h1234, 5'd7, 5'd7, 1'b0, 64'd0);
        cycle(1'b0, 5'd0, 64'd0,    5'd7, 5'd7, 1'b0, 64'd0);

        // commit aligned with a write to a0
        cycle(1'b1, 5'd10, 64'd5, 5'd10, 5'd0, 1'b1, 64'h8000_0000);
        cycle(1'b0, 5'd0, 64'd0,  5'd10, 5'd10, 1'b0, 64'd0);

        // back-to-back commits, commits without writes
        cycle(1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 1'b1, 64'h100);
        cycle(1'b1, 5'd2, 64'h77, 5'd2, 5'd1, 1'b1, 64'h104);
        cycle(1'b0, 5'd0, 64'd0, 5'd2, 5'd7, 1'b1, 64'h108);
        cycle(1'b0, 5'd0, 64'd0, 5'd2, 5'd7, 1'b0, 64'h10C);

        // retire counter wrap
        @(negedge clock);
        force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        force dut_nb.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        release dut_nb.retire_cnt_q;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, 64'h200);
        cycle(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, 64'h204);

        for (int n = 0; n < 300; n++) begin
            cycle($urandom_range(0, 3) != 0, 5'($urandom), {$urandom, $urandom},
                  5'($urandom), 5'($urandom), $urandom_range(0, 1) == 1,
                  {32'd0, $urandom & 32'hFFFF_FFFC});
        end

        // reset mid-run with x5 written and a commit pending
        cycle(1'b1, 5'd5, 64'hCAFE, 5'd5, 5'd5, 1'b1, 64'h300);
        @(negedge clock);
        wen = 1'b0; commit_valid = 1'b1; commit_pc = 64'h304;
        rs1_addr = 5'd5; rs2_addr = 5'd7;
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        check_trace();
        wen = 1'b0; commit_valid = 1'b0;
        #1;
        chk("rs1_after_reset", rs1_data, 64'd0);
        chk("rs2_after_reset", rs2_data, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        cycle(1'b0, 5'd0, 64'd0, 5'd5, 5'd7, 1'b0, 64'd0);

        for (int n = 0; n < 50; n++) begin
            cycle($urandom_range(0, 1) == 1, 5'($urandom), {$urandom, $urandom},
                  5'($urandom), 5'($urandom), $urandom_range(0, 1) == 1,
                  {32'd0, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
